// File: rtl/sram_sp_be_arbiter.sv
// Two-requester round-robin arbiter and command sequencer for a single-port bit-enable SRAM.
// Read returns are steered back to their issuer through a small owner-tag FIFO.
module sram_sp_be_arbiter #(
  parameter int SIZE     = 32,
  parameter int SIZE_COL = 8,
  parameter int DATA_WD  = 32,
  parameter int SIZE_WD  = $clog2(SIZE),
  parameter int COL_NUM  = DATA_WD / SIZE_COL
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               a_req_val_i,
  output logic               a_req_rdy_o,
  input  logic               a_req_wr_i,
  input  logic [SIZE_WD-1:0] a_req_adr_i,
  input  logic [COL_NUM-1:0] a_req_msk_i,
  input  logic [DATA_WD-1:0] a_req_dat_i,
  output logic               a_rsp_val_o,
  output logic [DATA_WD-1:0] a_rsp_dat_o,
  input  logic               b_req_val_i,
  output logic               b_req_rdy_o,
  input  logic               b_req_wr_i,
  input  logic [SIZE_WD-1:0] b_req_adr_i,
  input  logic [COL_NUM-1:0] b_req_msk_i,
  input  logic [DATA_WD-1:0] b_req_dat_i,
  output logic               b_rsp_val_o,
  output logic [DATA_WD-1:0] b_rsp_dat_o,
  output logic [SIZE_WD-1:0] sram_adr_o,
  output logic [COL_NUM-1:0] sram_wr_val_o,
  output logic [DATA_WD-1:0] sram_wr_dat_o,
  output logic               sram_rd_val_o,
  input  logic               sram_rd_val_i,
  input  logic [DATA_WD-1:0] sram_rd_dat_i,
  output logic               busy_o
);

  logic               last_b;
  logic               grant_a;
  logic               grant_b;
  logic               accept;
  logic               sel_wr;
  logic [SIZE_WD-1:0] sel_adr;
  logic [COL_NUM-1:0] sel_msk;
  logic [DATA_WD-1:0] sel_dat;

  logic [3:0]         tag_mem;
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [2:0]         count;
  logic               push;
  logic               pop;
  logic               head;

  // Grants are masked by reset so every output reads 0 while rstn is low.
  assign grant_a = rstn & a_req_val_i & (~b_req_val_i | last_b);
  assign grant_b = rstn & b_req_val_i & (~a_req_val_i | ~last_b);
  assign accept  = grant_a | grant_b;

  assign a_req_rdy_o = grant_a;
  assign b_req_rdy_o = grant_b;

  always_comb begin
    sel_wr  = a_req_wr_i;
    sel_adr = a_req_adr_i;
    sel_msk = a_req_msk_i;
    sel_dat = a_req_dat_i;
    if (grant_b) begin
      sel_wr  = b_req_wr_i;
      sel_adr = b_req_adr_i;
      sel_msk = b_req_msk_i;
      sel_dat = b_req_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_b <= 1'b1;
    end else if (accept) begin
      last_b <= grant_b;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sram_adr_o    <= '0;
      sram_wr_val_o <= '0;
      sram_wr_dat_o <= '0;
      sram_rd_val_o <= 1'b0;
    end else if (accept) begin
      sram_adr_o <= sel_adr;
      if (sel_wr) begin
        sram_wr_val_o <= sel_msk;
        sram_wr_dat_o <= sel_dat;
        sram_rd_val_o <= 1'b0;
      end else begin
        sram_wr_val_o <= '0;
        sram_rd_val_o <= 1'b1;
      end
    end else begin
      sram_wr_val_o <= '0;
      sram_rd_val_o <= 1'b0;
    end
  end

  // Owner tags: 0 = A, 1 = B, one per outstanding read, oldest at rd_ptr.
  assign push   = accept & ~sel_wr;
  assign pop    = sram_rd_val_i & (count != 3'd0);
  assign head   = tag_mem[rd_ptr];
  assign busy_o = (count != 3'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant_b;
        wr_ptr          <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_rsp_val_o <= 1'b0;
      b_rsp_val_o <= 1'b0;
      a_rsp_dat_o <= '0;
      b_rsp_dat_o <= '0;
    end else begin
      a_rsp_val_o <= pop & ~head;
      b_rsp_val_o <= pop & head;
      if (pop && !head) a_rsp_dat_o <= sram_rd_dat_i;
      if (pop && head)  b_rsp_dat_o <= sram_rd_dat_i;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rstn) begin
      if (sram_rd_val_i && count == 3'd0)
        $display("sram_sp_be_arbiter: read return with empty tag FIFO at %0t", $time);
      if (push && !pop && count == 3'd4)
        $display("sram_sp_be_arbiter: tag FIFO push while full at %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_sram_sp_be_arbiter.sv
// Directed bench for sram_sp_be_arbiter: vector table for arbitration/command stage,
// hand sequences for latency, routing, reset and masking, with a behavioural SRAM.
module tb_sram_sp_be_arbiter;

  logic        clk;
  logic        rstn;
  logic        a_req_val_i, a_req_rdy_o, a_req_wr_i;
  logic [4:0]  a_req_adr_i;
  logic [3:0]  a_req_msk_i;
  logic [31:0] a_req_dat_i;
  logic        a_rsp_val_o;
  logic [31:0] a_rsp_dat_o;
  logic        b_req_val_i, b_req_rdy_o, b_req_wr_i;
  logic [4:0]  b_req_adr_i;
  logic [3:0]  b_req_msk_i;
  logic [31:0] b_req_dat_i;
  logic        b_rsp_val_o;
  logic [31:0] b_rsp_dat_o;
  logic [4:0]  sram_adr_o;
  logic [3:0]  sram_wr_val_o;
  logic [31:0] sram_wr_dat_o;
  logic        sram_rd_val_o;
  logic        sram_rd_val_i;
  logic [31:0] sram_rd_dat_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  sram_sp_be_arbiter dut (
    .clk(clk), .rstn(rstn),
    .a_req_val_i(a_req_val_i), .a_req_rdy_o(a_req_rdy_o), .a_req_wr_i(a_req_wr_i),
    .a_req_adr_i(a_req_adr_i), .a_req_msk_i(a_req_msk_i), .a_req_dat_i(a_req_dat_i),
    .a_rsp_val_o(a_rsp_val_o), .a_rsp_dat_o(a_rsp_dat_o),
    .b_req_val_i(b_req_val_i), .b_req_rdy_o(b_req_rdy_o), .b_req_wr_i(b_req_wr_i),
    .b_req_adr_i(b_req_adr_i), .b_req_msk_i(b_req_msk_i), .b_req_dat_i(b_req_dat_i),
    .b_rsp_val_o(b_rsp_val_o), .b_rsp_dat_o(b_rsp_dat_o),
    .sram_adr_o(sram_adr_o), .sram_wr_val_o(sram_wr_val_o), .sram_wr_dat_o(sram_wr_dat_o),
    .sram_rd_val_o(sram_rd_val_o), .sram_rd_val_i(sram_rd_val_i), .sram_rd_dat_i(sram_rd_dat_i),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM with one or two cycles of read latency selected by regout.
  logic [31:0] mem [32];
  logic        regout;
  logic        p1_val, p2_val;
  logic [31:0] p1_dat, p2_dat;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p1_val <= 1'b0;
      p2_val <= 1'b0;
    end else begin
      p1_val <= sram_rd_val_o;
      if (sram_rd_val_o) p1_dat <= mem[sram_adr_o];
      for (int c = 0; c < 4; c++)
        if (sram_wr_val_o[c]) mem[sram_adr_o][c*8 +: 8] <= sram_wr_dat_o[c*8 +: 8];
      p2_val <= p1_val;
      p2_dat <= p1_dat;
    end
  end

  assign sram_rd_val_i = regout ? p2_val : p1_val;
  assign sram_rd_dat_i = regout ? p2_dat : p1_dat;

  typedef struct {
    logic        side;
    logic [31:0] dat;
  } rsp_t;

  rsp_t exp_q[$];
  logic mon_en;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every response pulse is matched against the oldest expected response.
  always begin
    rsp_t e;
    @(posedge clk);
    #1;
    if (mon_en && rstn && (a_rsp_val_o || b_rsp_val_o)) begin
      if (a_rsp_val_o && b_rsp_val_o) begin
        check_output("rsp_both_pulsed", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check_output("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("rsp_side", {31'd0, b_rsp_val_o}, {31'd0, e.side});
        check_output("rsp_dat", b_rsp_val_o ? b_rsp_dat_o : a_rsp_dat_o, e.dat);
      end
    end
  end

  typedef struct {
    logic        a_val, a_wr;
    logic [4:0]  a_adr;
    logic [3:0]  a_msk;
    logic [31:0] a_dat;
    logic        b_val, b_wr;
    logic [4:0]  b_adr;
    logic [3:0]  b_msk;
    logic [31:0] b_dat;
    logic        exp_a_rdy, exp_b_rdy, exp_rd;
    logic [3:0]  exp_wr;
    logic [4:0]  exp_adr;
    logic [31:0] exp_wdat;
  } vec_t;

  task automatic apply_stimulus(input vec_t v);
    a_req_val_i = v.a_val; a_req_wr_i = v.a_wr; a_req_adr_i = v.a_adr;
    a_req_msk_i = v.a_msk; a_req_dat_i = v.a_dat;
    b_req_val_i = v.b_val; b_req_wr_i = v.b_wr; b_req_adr_i = v.b_adr;
    b_req_msk_i = v.b_msk; b_req_dat_i = v.b_dat;
  endtask

  task automatic idle_inputs();
    a_req_val_i = 0; a_req_wr_i = 0; a_req_adr_i = 0; a_req_msk_i = 0; a_req_dat_i = 0;
    b_req_val_i = 0; b_req_wr_i = 0; b_req_adr_i = 0; b_req_msk_i = 0; b_req_dat_i = 0;
  endtask

  // Single command from one side; returns one time unit after its acceptance edge.
  task automatic send(input logic side, input logic wr, input logic [4:0] adr,
                      input logic [3:0] msk, input logic [31:0] dat, input logic [31:0] exp_rsp);
    idle_inputs();
    if (side) begin
      b_req_val_i = 1; b_req_wr_i = wr; b_req_adr_i = adr; b_req_msk_i = msk; b_req_dat_i = dat;
    end else begin
      a_req_val_i = 1; a_req_wr_i = wr; a_req_adr_i = adr; a_req_msk_i = msk; a_req_dat_i = dat;
    end
    #1;
    check_output("send_rdy", {31'd0, side ? b_req_rdy_o : a_req_rdy_o}, 32'd1);
    if (!wr) exp_q.push_back('{side, exp_rsp});
    tick();
    idle_inputs();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 20) begin
      tick();
      n++;
    end
    check_output("drain_busy", {31'd0, busy_o}, 32'd0);
    check_output("drain_queue", exp_q.size(), 32'd0);
  endtask

  task automatic wait_rsp(input logic side, output int lat);
    lat = 1;
    while (lat < 12 && !(side ? b_rsp_val_o : a_rsp_val_o)) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_rdy"}, {30'd0, a_req_rdy_o, b_req_rdy_o}, 32'd0);
    check_output({tag, "_rsp_val"}, {30'd0, a_rsp_val_o, b_rsp_val_o}, 32'd0);
    check_output({tag, "_a_rsp_dat"}, a_rsp_dat_o, 32'd0);
    check_output({tag, "_b_rsp_dat"}, b_rsp_dat_o, 32'd0);
    check_output({tag, "_sram_cmd"}, {22'd0, sram_adr_o, sram_wr_val_o, sram_rd_val_o}, 32'd0);
    check_output({tag, "_sram_wdat"}, sram_wr_dat_o, 32'd0);
    check_output({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[8];
    int   lat;
    logic b_seen;

    vecs[0] = '{1,0,5'd3,4'h0,32'h0,          0,0,5'd0,4'h0,32'h0,          1,0,1,4'h0,5'd3,32'h0};
    vecs[1] = '{0,0,5'd0,4'h0,32'h0,          1,1,5'd4,4'h3,32'h12345678,   0,1,0,4'h3,5'd4,32'h12345678};
    vecs[2] = '{1,0,5'd6,4'h0,32'h0,          1,0,5'd9,4'h0,32'h0,          1,0,1,4'h0,5'd6,32'h12345678};
    vecs[3] = '{1,0,5'd6,4'h0,32'h0,          1,0,5'd9,4'h0,32'h0,          0,1,1,4'h0,5'd9,32'h12345678};
    vecs[4] = '{0,0,5'd0,4'h0,32'h0,          0,0,5'd0,4'h0,32'h0,          0,0,0,4'h0,5'd9,32'h12345678};
    vecs[5] = '{1,1,5'd10,4'h8,32'hCAFEF00D,  1,1,5'd11,4'h1,32'h0BADBEEF,  1,0,0,4'h8,5'd10,32'hCAFEF00D};
    vecs[6] = '{1,1,5'd12,4'h0,32'h77777777,  0,0,5'd0,4'h0,32'h0,          1,0,0,4'h0,5'd12,32'h77777777};
    vecs[7] = '{1,0,5'd13,4'h0,32'h0,         1,0,5'd14,4'h0,32'h0,         0,1,1,4'h0,5'd14,32'h77777777};

    mon_en = 0;
    regout = 0;
    rstn   = 0;
    idle_inputs();
    #3;
    check_all_zero("reset");
    tick();
    tick();
    rstn = 1;
    #1;
    check_all_zero("post_reset");

    // Arbitration and command-stage vectors.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d_rdy", i), {30'd0, a_req_rdy_o, b_req_rdy_o},
                   {30'd0, vecs[i].exp_a_rdy, vecs[i].exp_b_rdy});
      tick();
      check_output($sformatf("vec%0d_cmd", i), {22'd0, sram_adr_o, sram_wr_val_o, sram_rd_val_o},
                   {22'd0, vecs[i].exp_adr, vecs[i].exp_wr, vecs[i].exp_rd});
      check_output($sformatf("vec%0d_wdat", i), sram_wr_dat_o, vecs[i].exp_wdat);
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) tick();
    wait_idle();
    mon_en = 1;

    $display("[TB] full write then read latency");
    send(0, 1, 5'd1, 4'hF, 32'hA1A1A1A1, 32'h0);
    send(0, 1, 5'd5, 4'hF, 32'hDEADBEEF, 32'h0);
    send(0, 0, 5'd5, 4'h0, 32'h0, 32'hDEADBEEF);
    b_seen = 0;
    lat = 1;
    while (lat < 12 && !a_rsp_val_o) begin
      if (b_rsp_val_o) b_seen = 1;
      tick();
      lat++;
    end
    check_output("seq1_latency", lat, 32'd3);
    check_output("seq1_a_dat", a_rsp_dat_o, 32'hDEADBEEF);
    check_output("seq1_no_b", {31'd0, b_seen | b_rsp_val_o}, 32'd0);
    wait_idle();

    $display("[TB] partial column write");
    send(0, 1, 5'd2, 4'hF, 32'h11223344, 32'h0);
    send(1, 1, 5'd2, 4'h5, 32'hAABBCCDD, 32'h0);
    send(1, 0, 5'd2, 4'h0, 32'h0, 32'h11BB33DD);
    wait_rsp(1, lat);
    check_output("seq2_latency", lat, 32'd3);
    check_output("seq2_b_dat", b_rsp_dat_o, 32'h11BB33DD);
    wait_idle();

    $display("[TB] contention alternates");
    idle_inputs();
    a_req_val_i = 1; a_req_adr_i = 5'd1;
    b_req_val_i = 1; b_req_adr_i = 5'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_output($sformatf("seq3_grant%0d", k), {30'd0, a_req_rdy_o, b_req_rdy_o},
                   (k % 2 == 0) ? 32'd2 : 32'd1);
      if (k % 2 == 0) exp_q.push_back('{1'b0, 32'hA1A1A1A1});
      else            exp_q.push_back('{1'b1, 32'h11BB33DD});
      tick();
    end
    idle_inputs();
    wait_idle();

    $display("[TB] two-cycle SRAM latency, back-to-back reads");
    regout = 1;
    send(0, 0, 5'd1, 4'h0, 32'h0, 32'hA1A1A1A1);
    check_output("seq4_busy_e0", {31'd0, busy_o}, 32'd1);
    send(1, 0, 5'd2, 4'h0, 32'h0, 32'h11BB33DD);
    check_output("seq4_busy_e1", {31'd0, busy_o}, 32'd1);
    send(0, 0, 5'd5, 4'h0, 32'h0, 32'hDEADBEEF);
    check_output("seq4_busy_e2", {31'd0, busy_o}, 32'd1);
    tick();
    check_output("seq4_e3", {29'd0, busy_o, a_rsp_val_o, b_rsp_val_o}, 32'b110);
    tick();
    check_output("seq4_e4", {29'd0, busy_o, a_rsp_val_o, b_rsp_val_o}, 32'b101);
    tick();
    check_output("seq4_e5", {29'd0, busy_o, a_rsp_val_o, b_rsp_val_o}, 32'b010);
    wait_idle();
    regout = 0;

    $display("[TB] reset with reads in flight");
    send(1, 0, 5'd2, 4'h0, 32'h0, 32'h11BB33DD);
    send(0, 0, 5'd1, 4'h0, 32'h0, 32'hA1A1A1A1);
    a_req_val_i = 1; a_req_adr_i = 5'd5;
    b_req_val_i = 1; b_req_adr_i = 5'd2;
    rstn = 0;
    exp_q.delete();
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    rstn = 1;
    #1;
    check_output("seq5_first_grant", {30'd0, a_req_rdy_o, b_req_rdy_o}, 32'd2);
    exp_q.push_back('{1'b0, 32'hDEADBEEF});
    tick();
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();
    wait_idle();

    $display("[TB] all-zero mask write");
    send(0, 1, 5'd7, 4'hF, 32'h00000005, 32'h0);
    send(0, 1, 5'd7, 4'h0, 32'hFFFFFFFF, 32'h0);
    check_output("seq6_wr_val_noop", {28'd0, sram_wr_val_o}, 32'd0);
    send(0, 0, 5'd7, 4'h0, 32'h0, 32'h00000005);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("seq6_wr_val%0d", i), {28'd0, sram_wr_val_o}, 32'd0);
      tick();
    end
    check_output("seq6_a_dat", a_rsp_dat_o, 32'h00000005);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
